// File: rtl/wait_event_pkg.sv
// Shared types for the wait-event monitor: event kinds, FSM states and the
// timeout encoding that means "wait forever".
package wait_event_pkg;

  typedef enum logic [1:0] {
    RISE = 2'd0,
    FALL = 2'd1,
    HIGH = 2'd2,
    LOW  = 2'd3
  } wait_type_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WAIT   = 2'd1,
    REPORT = 2'd2
  } wait_state_t;

  localparam int TIMEOUT_INFINITE = 0;

endpackage

// File: rtl/wait_event_detect.sv
// Picks one bit out of the current/previous sample vectors and evaluates the
// requested edge or level condition on it.
module wait_event_detect
  import wait_event_pkg::*;
#(
  parameter int WAIT_SIZE = 16,
  parameter int SEL_W     = 5
) (
  input  logic [WAIT_SIZE-1:0] cur_i,
  input  logic [WAIT_SIZE-1:0] prev_i,
  input  logic [SEL_W-1:0]     sel_i,
  input  wait_type_t           type_i,
  output logic                 hit_o
);

  logic cur_b;
  logic prev_b;

  // Loop mux keeps out-of-range selects at zero without a wide index.
  always_comb begin
    cur_b  = 1'b0;
    prev_b = 1'b0;
    for (int i = 0; i < WAIT_SIZE; i++) begin
      if (sel_i == SEL_W'(i)) begin
        cur_b  = cur_i[i];
        prev_b = prev_i[i];
      end
    end
  end

  always_comb begin
    hit_o = 1'b0;
    case (type_i)
      RISE:    hit_o = cur_b & ~prev_b;
      FALL:    hit_o = ~cur_b & prev_b;
      HIGH:    hit_o = cur_b;
      LOW:     hit_o = ~cur_b;
      default: hit_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/wait_event_ctrl.sv
// Wait-command monitor: accepts one wait at a time, counts cycles until the
// selected bit shows the event or the timeout expires, then reports.
module wait_event_ctrl
  import wait_event_pkg::*;
#(
  parameter int WAIT_SIZE = 16,
  parameter int SEL_W     = 5,
  parameter int TIMEOUT_W = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [WAIT_SIZE-1:0] i_wait_signals,
  input  logic                 i_cmd_valid,
  output logic                 o_cmd_ready,
  input  logic [SEL_W-1:0]     i_cmd_sel,
  input  logic [1:0]           i_cmd_type,
  input  logic [TIMEOUT_W-1:0] i_cmd_timeout,
  input  logic                 i_abort,
  output logic                 o_done,
  output logic                 o_timeout_err,
  output logic                 o_sel_err,
  output logic [TIMEOUT_W-1:0] o_elapsed
);

  wait_state_t          state_q, state_d;
  logic [WAIT_SIZE-1:0] prev_q;
  logic [SEL_W-1:0]     sel_q, sel_d;
  wait_type_t           type_q, type_d;
  logic [TIMEOUT_W-1:0] tmo_q, tmo_d;
  logic [TIMEOUT_W-1:0] cnt_q, cnt_d;
  logic [TIMEOUT_W-1:0] elapsed_q, elapsed_d;
  logic                 terr_q, terr_d;
  logic                 serr_q, serr_d;

  logic                 hit;
  logic                 sel_bad;
  logic                 expired;
  logic [TIMEOUT_W-1:0] cnt_inc;

  wait_event_detect #(
    .WAIT_SIZE (WAIT_SIZE),
    .SEL_W     (SEL_W)
  ) u_detect (
    .cur_i  (i_wait_signals),
    .prev_i (prev_q),
    .sel_i  (sel_q),
    .type_i (type_q),
    .hit_o  (hit)
  );

  // Saturate instead of wrapping so an infinite wait never reports a small count.
  assign cnt_inc = (&cnt_q) ? cnt_q : cnt_q + TIMEOUT_W'(1);
  assign sel_bad = int'(i_cmd_sel) >= WAIT_SIZE;
  assign expired = (tmo_q != TIMEOUT_W'(TIMEOUT_INFINITE)) && (cnt_inc == tmo_q);

  always_comb begin
    state_d   = state_q;
    sel_d     = sel_q;
    type_d    = type_q;
    tmo_d     = tmo_q;
    cnt_d     = cnt_q;
    elapsed_d = elapsed_q;
    terr_d    = terr_q;
    serr_d    = serr_q;
    case (state_q)
      IDLE: begin
        if (i_cmd_valid) begin
          sel_d     = i_cmd_sel;
          type_d    = wait_type_t'(i_cmd_type);
          tmo_d     = i_cmd_timeout;
          cnt_d     = '0;
          elapsed_d = '0;
          terr_d    = 1'b0;
          serr_d    = sel_bad;
          state_d   = sel_bad ? REPORT : WAIT;
        end
      end
      WAIT: begin
        cnt_d     = cnt_inc;
        elapsed_d = cnt_inc;
        // Abort beats completion; a hit beats a same-cycle timeout.
        if (i_abort) begin
          state_d = IDLE;
        end else if (hit) begin
          terr_d  = 1'b0;
          state_d = REPORT;
        end else if (expired) begin
          terr_d  = 1'b1;
          state_d = REPORT;
        end
      end
      REPORT:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      prev_q    <= '0;
      sel_q     <= '0;
      type_q    <= RISE;
      tmo_q     <= '0;
      cnt_q     <= '0;
      elapsed_q <= '0;
      terr_q    <= 1'b0;
      serr_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      prev_q    <= i_wait_signals;
      sel_q     <= sel_d;
      type_q    <= type_d;
      tmo_q     <= tmo_d;
      cnt_q     <= cnt_d;
      elapsed_q <= elapsed_d;
      terr_q    <= terr_d;
      serr_q    <= serr_d;
    end
  end

  assign o_cmd_ready   = (state_q == IDLE);
  assign o_done        = (state_q == REPORT);
  assign o_timeout_err = o_done & terr_q;
  assign o_sel_err     = o_done & serr_q;
  assign o_elapsed     = elapsed_q;

endmodule

// File: tb/tb_wait_event_ctrl.sv
// Bench for wait_event_ctrl: fixed vector table, random commands against a
// trace-scanning model, plus abort and mid-wait reset sequences.
module tb_wait_event_ctrl;
  import wait_event_pkg::*;

  localparam int WS  = 16;
  localparam int SW  = 5;
  localparam int TW  = 32;
  localparam int TRL = 320;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [WS-1:0] sig;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [SW-1:0] cmd_sel;
  logic [1:0]    cmd_type;
  logic [TW-1:0] cmd_tmo;
  logic          abort;
  logic          done;
  logic          terr;
  logic          serr;
  logic [TW-1:0] elapsed;

  int checks   = 0;
  int failures = 0;

  // tr[0] is the vector during the accept cycle, tr[k] during WAIT cycle k.
  logic [WS-1:0] tr [0:TRL-1];
  logic [WS-1:0] pre;

  typedef struct {
    int         sel;
    wait_type_t typ;
    int         tmo;
    bit         pre_b;
    bit         init_b;
    int         chg;
    int         exp_el;
    bit         exp_to;
    bit         exp_se;
  } vec_t;

  vec_t vt [0:9];

  always #5 clk = ~clk;

  wait_event_ctrl #(
    .WAIT_SIZE (WS),
    .SEL_W     (SW),
    .TIMEOUT_W (TW)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .i_wait_signals (sig),
    .i_cmd_valid    (cmd_valid),
    .o_cmd_ready    (cmd_ready),
    .i_cmd_sel      (cmd_sel),
    .i_cmd_type     (cmd_type),
    .i_cmd_timeout  (cmd_tmo),
    .i_abort        (abort),
    .o_done         (done),
    .o_timeout_err  (terr),
    .o_sel_err      (serr),
    .o_elapsed      (elapsed)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [WS-1:0] setb(input logic [WS-1:0] v, input int i, input bit b);
    logic [WS-1:0] m;
    m = WS'(1) << i;
    return b ? (v | m) : (v & ~m);
  endfunction

  function automatic bit bitof(input logic [WS-1:0] v, input int i);
    logic [WS-1:0] s;
    s = v >> i;
    return s[0];
  endfunction

  // Scan the trace for the first WAIT cycle whose bit history satisfies the
  // event, bounded by the timeout; returns that cycle number (-1 if none).
  function automatic int model_k(input int sel, input wait_type_t typ, input int tmo,
                                 output bit to);
    bit c, p, h;
    to = 1'b0;
    if (sel >= WS) return 0;
    for (int k = 1; k < TRL - 4; k++) begin
      c = bitof(tr[k], sel);
      p = bitof(tr[k-1], sel);
      case (typ)
        RISE:    h = c && !p;
        FALL:    h = !c && p;
        HIGH:    h = c;
        default: h = !c;
      endcase
      if (h) return k;
      if (tmo != 0 && k == tmo) begin
        to = 1'b1;
        return k;
      end
    end
    return -1;
  endfunction

  // Issue one command from IDLE and follow it to completion; done must first
  // appear in cycle exp_el+1 after accept, and ready must return one cycle later.
  task automatic run_cmd(input string nm, input int sel, input wait_type_t typ, input int tmo,
                         input int exp_el, input bit exp_to, input bit exp_se, input bit noise);
    int cyc;
    bit seen;
    chk({nm, " ready_before"}, cmd_ready, 1);
    sig = pre;
    cmd_valid = 1'b0;
    step();
    sig       = tr[0];
    cmd_valid = 1'b1;
    cmd_sel   = SW'(sel);
    cmd_type  = typ;
    cmd_tmo   = TW'(tmo);
    step();
    chk({nm, " ready_busy"}, cmd_ready, 0);
    cyc  = 1;
    seen = 1'b0;
    while (!seen && cyc <= exp_el + 3) begin
      if (done) begin
        seen = 1'b1;
        chk({nm, " done_cycle"}, cyc, exp_el + 1);
        chk({nm, " elapsed"}, elapsed, exp_el);
        chk({nm, " timeout_err"}, terr, exp_to);
        chk({nm, " sel_err"}, serr, exp_se);
        cmd_valid = 1'b0;
      end else begin
        cmd_valid = noise ? 1'($urandom_range(0, 1)) : 1'b0;
        cmd_sel   = SW'($urandom_range(0, 31));
        cmd_type  = 2'($urandom_range(0, 3));
        cmd_tmo   = TW'($urandom_range(0, 50));
      end
      sig = tr[cyc];
      step();
      cyc++;
    end
    chk({nm, " done_seen"}, seen, 1);
    cmd_valid = 1'b0;
    chk({nm, " ready_after"}, cmd_ready, 1);
    chk({nm, " done_after"}, done, 0);
  endtask

  initial begin
    logic [WS-1:0] base;
    logic [WS-1:0] flips;
    int            sel, tmo, k, quiet;
    wait_type_t    typ;
    bit            to;

    vt[0] = '{3,  RISE, 100, 1'b0, 1'b0, 10, 10, 1'b0, 1'b0};
    vt[1] = '{0,  FALL, 5,   1'b1, 1'b1, 0,  5,  1'b1, 1'b0};
    vt[2] = '{15, HIGH, 0,   1'b1, 1'b1, 0,  1,  1'b0, 1'b0};
    vt[3] = '{2,  RISE, 4,   1'b0, 1'b0, 4,  4,  1'b0, 1'b0};
    vt[4] = '{20, RISE, 7,   1'b0, 1'b0, 0,  0,  1'b0, 1'b1};
    vt[5] = '{9,  FALL, 0,   1'b1, 1'b1, 1,  1,  1'b0, 1'b0};
    vt[6] = '{1,  RISE, 6,   1'b0, 1'b1, 0,  6,  1'b1, 1'b0};
    vt[7] = '{5,  LOW,  3,   1'b1, 1'b1, 3,  3,  1'b0, 1'b0};
    vt[8] = '{6,  RISE, 3,   1'b0, 1'b0, 4,  3,  1'b1, 1'b0};
    vt[9] = '{12, LOW,  0,   1'b0, 1'b0, 0,  1,  1'b0, 1'b0};

    rst_n     = 1'b0;
    sig       = '0;
    cmd_valid = 1'b0;
    cmd_sel   = '0;
    cmd_type  = '0;
    cmd_tmo   = '0;
    abort     = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset ready", cmd_ready, 1);
    chk("reset done", done, 0);
    chk("reset timeout_err", terr, 0);
    chk("reset sel_err", serr, 0);
    chk("reset elapsed", elapsed, 0);
    @(negedge clk);
    rst_n = 1'b1;
    step();

    for (int v = 0; v < 10; v++) begin
      base = WS'($urandom);
      pre  = setb(base, vt[v].sel, vt[v].pre_b);
      for (int c = 0; c < TRL; c++)
        tr[c] = setb(base, vt[v].sel,
                     (vt[v].chg != 0 && c >= vt[v].chg) ? !vt[v].init_b : vt[v].init_b);
      run_cmd($sformatf("vec%0d", v), vt[v].sel, vt[v].typ, vt[v].tmo,
              vt[v].exp_el, vt[v].exp_to, vt[v].exp_se, 1'b0);
    end

    // Abort a LOW wait on a bit held high during WAIT cycle 30.
    sig       = '1;
    cmd_valid = 1'b1;
    cmd_sel   = SW'(7);
    cmd_type  = LOW;
    cmd_tmo   = '0;
    step();
    cmd_valid = 1'b0;
    quiet     = 1;
    for (int c = 1; c < 30; c++) begin
      if (done) quiet = 0;
      step();
    end
    if (done) quiet = 0;
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("abort no_done", quiet, 1);
    chk("abort ready", cmd_ready, 1);
    chk("abort done", done, 0);
    chk("abort elapsed", elapsed, 30);
    step();

    for (int r = 0; r < 40; r++) begin
      sel = $urandom_range(0, 17);
      typ = wait_type_t'(2'($urandom_range(0, 3)));
      tmo = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(1, 40);
      pre   = WS'($urandom);
      tr[0] = WS'($urandom);
      for (int c = 1; c < TRL; c++) begin
        flips = '0;
        for (int b = 0; b < WS; b++)
          if ($urandom_range(0, 7) == 0) flips = setb(flips, b, 1'b1);
        tr[c] = tr[c-1] ^ flips;
      end
      k = model_k(sel, typ, tmo, to);
      if (k < 0) begin
        tmo = TRL - 10;
        k   = model_k(sel, typ, tmo, to);
      end
      run_cmd($sformatf("rand%0d", r), sel, typ, tmo, k, to, sel >= WS, 1'b1);
    end

    // Asynchronous reset in the middle of a wait.
    sig       = '0;
    cmd_valid = 1'b1;
    cmd_sel   = SW'(4);
    cmd_type  = RISE;
    cmd_tmo   = '0;
    step();
    cmd_valid = 1'b0;
    repeat (4) step();
    chk("midrst elapsed_before", elapsed, 4);
    chk("midrst ready_before", cmd_ready, 0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst ready", cmd_ready, 1);
    chk("midrst done", done, 0);
    chk("midrst timeout_err", terr, 0);
    chk("midrst sel_err", serr, 0);
    chk("midrst elapsed", elapsed, 0);
    @(negedge clk);
    rst_n = 1'b1;
    sig   = setb('0, 4, 1'b1);
    quiet = 1;
    for (int c = 0; c < 5; c++) begin
      step();
      if (done || !cmd_ready) quiet = 0;
    end
    chk("midrst stays_idle", quiet, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
